// File: rtl/reset_sequencer_if.sv
// Signal bundle between the ADPLL reset sequencer and the stages it controls.
// master: the sequencer side; slave: the stage/requester side.
interface reset_sequencer_if #(
  parameter int N_STAGES = 4
);
  logic                soft_rst_req;
  logic [N_STAGES-1:0] stage_ready;
  logic [N_STAGES-1:0] stage_rst;
  logic [2:0]          cur_stage;
  logic                seq_busy;
  logic                seq_done;
  logic                fault;

  modport master (
    input  soft_rst_req, stage_ready,
    output stage_rst, cur_stage, seq_busy, seq_done, fault
  );

  modport slave (
    output soft_rst_req, stage_ready,
    input  stage_rst, cur_stage, seq_busy, seq_done, fault
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release for the ADPLL stages: hold all, then release in index order on ready.
// Define RST_SEQ_TIMEOUT_EN to add the stage-ready timeout and FAULT state.
//
// state      | meaning
// S_HOLD     | all stages in reset, counting the settle time
// S_WAIT_RDY | stages 0..cur_stage released, waiting on stage_ready[cur_stage]
// S_DONE     | all stages released and ready, outputs frozen
// S_FAULT    | stage_ready timeout; all stages back in reset (timeout build only)
module reset_sequencer #(
  parameter int N_STAGES       = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_async_n,
  reset_sequencer_if.master bus
);

`ifdef RST_SEQ_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_DONE     = 2'd2,
    S_FAULT    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_DONE     = 2'd2
  } state_t;
`endif

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam logic [CNT_W-1:0]    HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_SAT    = CNT_W'(CNT_MAX);
  localparam logic [2:0]          LAST_STAGE = 3'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] ONE_HOT0   = N_STAGES'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          stage_q, stage_d;
  logic [N_STAGES-1:0] rst_q, rst_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                ready_cur;

  // Masked select keeps the index in range for any N_STAGES below 8.
  assign ready_cur = |(bus.stage_ready & (ONE_HOT0 << stage_q));
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    if (bus.soft_rst_req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '1;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_RDY;
            cnt_d   = '0;
            stage_d = '0;
            rst_d   = rst_q & ~ONE_HOT0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT_RDY: begin
          if (ready_cur) begin
            if (stage_q == LAST_STAGE) begin
              state_d = S_DONE;
            end else begin
              stage_d = stage_q + 3'd1;
              rst_d   = rst_q & ~(ONE_HOT0 << (stage_q + 3'd1));
              cnt_d   = '0;
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_FAULT;
            rst_d   = '1;
          end else begin
            cnt_d = cnt_inc;
          end
`endif
        end
        S_DONE: begin
          state_d = S_DONE;
        end
`ifdef RST_SEQ_TIMEOUT_EN
        S_FAULT: begin
          state_d = S_FAULT;
        end
`endif
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          stage_d = '0;
          rst_d   = '1;
        end
      endcase
    end
  end

  assign bus.stage_rst = rst_q;
  assign bus.cur_stage = stage_q;
  assign bus.seq_busy  = (state_q == S_HOLD) || (state_q == S_WAIT_RDY);
  assign bus.seq_done  = (state_q == S_DONE);
`ifdef RST_SEQ_TIMEOUT_EN
  assign bus.fault     = (state_q == S_FAULT);
`else
  assign bus.fault     = 1'b0;
`endif

endmodule
